vga_timing_gen: RTL

- Produces VGA raster timing (640x480 @ 60 Hz from 50 MHz Clk) and the current pixel coordinates DrawX/DrawY.
- These coordinates drive the pixel-colour path (ball logic, colour mapping) and the board VGA DAC.
- It is the producer end of the DrawX/DrawY/blank interface; downstream colour logic consumes it.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator (640x480 @ 60 Hz from a 50 MHz Clk by default).
//   Produces the pixel clock (Clk/2), active-low syncs, the blanking flag and the
//   current pixel coordinates DrawX/DrawY that feed the downstream colour path.
//
//   Optional build macro: VGA_FRAME_COUNT_EN
//     defined   -> frame_count counts completed frames (wraps at 16'hFFFF)
//     undefined -> frame_count is tied to 16'h0000 and no counter register exists
//
// Ports
//   Clk          in   system clock, all logic on rising edge
//   Reset        in   synchronous active-high reset
//   VGA_CLK      out  pixel clock, Clk/2, registered
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  high only inside the visible region
//   VGA_SYNC_N   out  constant 0 (no sync-on-green)
//   DrawX        out  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  vertical counter, 0..V_TOTAL-1
//   frame_start  out  one-Clk pulse on the first (0,0) after a frame wrap
//   frame_count  out  completed-frame counter
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The counters are 10 bits wide, so neither total may exceed 1024.
  if (H_TOTAL > 1024 || H_TOTAL < 2) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL must be in 2..1024");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL must be in 1..1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // Half-open window test lo <= v < hi, widened by one bit so a bound of 1024
  // is representable.
  function automatic logic in_window(input logic [9:0]  v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       at_end;

  // Next-state counters: advance only in the pixel-clock-high phase so every
  // coordinate is held for two Clk cycles.
  always_comb begin
    x_nxt  = DrawX;
    y_nxt  = DrawY;
    at_end = (DrawX == H_LAST) && (DrawY == V_LAST);
    if (VGA_CLK) begin
      if (DrawX == H_LAST) begin
        x_nxt = '0;
        y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
      end else begin
        x_nxt = DrawX + 10'd1;
      end
    end
  end

  // Sync and blank are decoded from the next-state counters so they land in
  // the same cycle as the coordinates they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      VGA_CLK     <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_CLK     <= ~VGA_CLK;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      VGA_HS      <= ~in_window(x_nxt, HS_START, HS_STOP);
      VGA_VS      <= ~in_window(y_nxt, VS_START, VS_STOP);
      VGA_BLANK_N <= in_window(x_nxt, 11'd0, H_VIS) && in_window(y_nxt, 11'd0, V_VIS);
      // Only a wrap out of the last pixel marks a frame start; the (0,0)
      // reached through reset never does.
      frame_start <= VGA_CLK && at_end;
    end
  end

  assign VGA_SYNC_N = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt <= '0;
    end else if (VGA_CLK && at_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'h0000;
`endif

endmodule
